// File: rtl/instr_loader.sv
// instr_loader: packs a byte stream big-endian into 32-bit words and writes them to the
// instruction RAM. Define INSTR_LOADER_CHECKSUM_EN to add an XOR trailer-byte check.
module instr_loader #(
   parameter int unsigned ADRS_W    = 7,
   parameter int unsigned MAX_WORDS = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [5:0]        num_words,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              wr_en,
   output logic [ADRS_W-1:0] wr_adrs,
   output logic [31:0]       wr_data,
   output logic              busy,
   output logic              done,
   output logic              chk_err
);

   localparam int unsigned IdxW   = ADRS_W - 2;
   localparam logic [5:0]  MaxNum = 6'(MAX_WORDS);

   typedef enum logic [2:0] {StIdle, StLoad, StWrite, StCheck, StDone} state_e;

`ifdef INSTR_LOADER_CHECKSUM_EN
   localparam state_e AfterLast = StCheck;
`else
   localparam state_e AfterLast = StDone;
`endif

   state_e            state_q, state_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [IdxW-1:0]   word_idx_q, word_idx_d;
   logic [5:0]        num_q, num_d;
   logic [23:0]       shift_q, shift_d;
   logic [31:0]       wr_data_q, wr_data_d;
   logic              xfer;
   logic              last_word;

   assign xfer      = byte_valid & byte_ready;
   assign last_word = (6'(word_idx_q) + 6'd1) == num_q;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = (num_words == 6'd0) ? StDone : StLoad;
            end
         end
         StLoad: begin
            if (xfer && (byte_cnt_q == 2'd3)) begin
               state_d = StWrite;
            end
         end
         StWrite: state_d = last_word ? AfterLast : StLoad;
         StCheck: begin
            if (xfer) begin
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output decode; all outputs depend on state only, so xfer has no combinational loop
   always_comb begin
      byte_ready = 1'b0;
      wr_en      = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      unique case (state_q)
         StIdle:          busy       = 1'b0;
         StLoad, StCheck: byte_ready = 1'b1;
         StWrite:         wr_en      = 1'b1;
         StDone:          done       = 1'b1;
         default:         busy       = 1'b0;
      endcase
   end

   assign wr_adrs = {word_idx_q, 2'b00};
   assign wr_data = wr_data_q;

   // Datapath next-state
   always_comb begin
      byte_cnt_d = byte_cnt_q;
      word_idx_d = word_idx_q;
      num_d      = num_q;
      shift_d    = shift_q;
      wr_data_d  = wr_data_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               num_d      = (num_words > MaxNum) ? MaxNum : num_words;
               byte_cnt_d = 2'd0;
               word_idx_d = '0;
               shift_d    = '0;
            end
         end
         StLoad: begin
            if (xfer) begin
               shift_d    = {shift_q[15:0], byte_in};
               byte_cnt_d = byte_cnt_q + 2'd1;
               // Capture the full word so wr_data holds it until the next write
               if (byte_cnt_q == 2'd3) begin
                  wr_data_d = {shift_q, byte_in};
               end
            end
         end
         StWrite: begin
            if (!last_word) begin
               word_idx_d = word_idx_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt_q <= 2'd0;
         word_idx_q <= '0;
         num_q      <= 6'd0;
         shift_q    <= 24'd0;
         wr_data_q  <= 32'd0;
      end else begin
         byte_cnt_q <= byte_cnt_d;
         word_idx_q <= word_idx_d;
         num_q      <= num_d;
         shift_q    <= shift_d;
         wr_data_q  <= wr_data_d;
      end
   end

`ifdef INSTR_LOADER_CHECKSUM_EN
   logic [7:0] acc_q, acc_d;
   logic       chk_err_q, chk_err_d;

   always_comb begin
      acc_d     = acc_q;
      chk_err_d = chk_err_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               acc_d     = 8'd0;
               chk_err_d = 1'b0;
            end
         end
         StLoad: begin
            if (xfer) begin
               acc_d = acc_q ^ byte_in;
            end
         end
         StCheck: begin
            if (xfer) begin
               chk_err_d = (byte_in != acc_q);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q     <= 8'd0;
         chk_err_q <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         chk_err_q <= chk_err_d;
      end
   end

   assign chk_err = chk_err_q;
`else
   assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed loads checked against a queue of expected RAM writes derived
// from the byte stream, plus literal expectations for the documented scenarios.
module tb_instr_loader;

   logic        clk = 1'b0;
   logic        rst, start, byte_valid;
   logic [5:0]  num_words;
   logic [7:0]  byte_in;
   logic        byte_ready, wr_en, busy, done, chk_err;
   logic [6:0]  wr_adrs;
   logic [31:0] wr_data;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   instr_loader dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .num_words  (num_words),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .wr_en      (wr_en),
      .wr_adrs    (wr_adrs),
      .wr_data    (wr_data),
      .busy       (busy),
      .done       (done),
      .chk_err    (chk_err)
   );

   logic [6:0]  exp_adrs_q[$];
   logic [31:0] exp_data_q[$];
   logic [7:0]  stream[$];
   logic        exp_chk = 1'b0;
   bit          expect_latency = 1'b0;
   int          cyc = 0, last_wr_cyc = -10, done_cnt = 0, wr_cnt = 0;
   logic [6:0]  last_adrs = '0;
   logic [31:0] last_data = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Compare process: every write and done pulse is checked against the model queue
   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         if (wr_en) begin
            wr_cnt++;
            check("ready_low_in_write", 32'(byte_ready), 32'd0);
            checks++;
            if (exp_adrs_q.size() == 0) begin
               $display("FAIL unexpected_write: got adrs %h data %h expected no write",
                        wr_adrs, wr_data);
            end else begin
               passes++;
               check("wr_adrs", 32'(wr_adrs), 32'(exp_adrs_q.pop_front()));
               check("wr_data", wr_data, exp_data_q.pop_front());
            end
            last_adrs   = wr_adrs;
            last_data   = wr_data;
            last_wr_cyc = cyc;
         end
         if (done) begin
            done_cnt++;
            check("done_chk_err", 32'(chk_err), 32'(exp_chk));
            check("writes_left_at_done", exp_adrs_q.size(), 32'd0);
`ifndef INSTR_LOADER_CHECKSUM_EN
            if (expect_latency) check("done_latency", cyc - last_wr_cyc, 32'd1);
`endif
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load(input logic [5:0] n);
      start     = 1'b1;
      num_words = n;
      tick();
      start     = 1'b0;
      num_words = 6'h2a;
   endtask

   task automatic send(input logic [7:0] b);
      bit acc = 1'b0;
      int k   = 0;
      byte_valid = 1'b1;
      byte_in    = b;
      do begin
         acc = byte_ready;
         tick();
         k++;
      end while (!acc && k < 20);
      check("byte_accepted", 32'(acc), 32'd1);
      byte_valid = 1'b0;
      byte_in    = 8'h5a;
   endtask

   task automatic wait_done(input string name);
      int k = 0;
      while (!done && k < 300) begin
         tick();
         k++;
      end
      check({name, "_done_seen"}, 32'(done), 32'd1);
      tick();
      check({name, "_done_one_cycle"}, 32'(done), 32'd0);
      check({name, "_idle_after"}, 32'(busy), 32'd0);
   endtask

   // Model: expected writes come straight from the stream, four bytes per word, MSB first
   task automatic run_load(input int n, input bit gapped, input bit bad_trailer, input bit poke);
      int         nw  = (n > 32) ? 32 : n;
      logic [7:0] sum = 8'd0;
      for (int w = 0; w < nw; w++) begin
         exp_adrs_q.push_back(7'(w * 4));
         exp_data_q.push_back({stream[4*w], stream[4*w+1], stream[4*w+2], stream[4*w+3]});
      end
      for (int i = 0; i < nw * 4; i++) sum ^= stream[i];
`ifdef INSTR_LOADER_CHECKSUM_EN
      exp_chk = bad_trailer;
`else
      exp_chk = 1'b0;
`endif
      expect_latency = (nw > 0);
      start_load(6'(n));
      for (int i = 0; i < nw * 4; i++) begin
         if (gapped) begin
            byte_valid = 1'b0;
            tick();
         end
         send(stream[i]);
         if (poke && i == 1) begin
            start     = 1'b1;
            num_words = 6'd3;
            tick();
            start     = 1'b0;
         end
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      if (nw > 0) send(bad_trailer ? (sum ^ 8'h01) : sum);
`else
      if (bad_trailer) sum = ~sum;
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int d0, w0;
      rst        = 1'b1;
      start      = 1'b1;
      num_words  = 6'd1;
      byte_valid = 1'b1;
      byte_in    = 8'hff;

      // Reset with stream active
      for (int i = 0; i < 2; i++) begin
         tick();
         check("rst_ready", 32'(byte_ready), 32'd0);
         check("rst_wr_en", 32'(wr_en), 32'd0);
         check("rst_busy", 32'(busy), 32'd0);
         check("rst_done", 32'(done), 32'd0);
         check("rst_chk_err", 32'(chk_err), 32'd0);
      end
      check("rst_wr_adrs", 32'(wr_adrs), 32'd0);
      check("rst_wr_data", wr_data, 32'd0);
      start      = 1'b0;
      byte_valid = 1'b0;
      rst        = 1'b0;
      tick();
      check("rst_no_writes", wr_cnt, 32'd0);

      // Single word
      stream = '{8'h00, 8'h45, 8'h06, 8'h93};
      run_load(1, 1'b0, 1'b0, 1'b0);
      wait_done("single");
      check("single_adrs", 32'(last_adrs), 32'd0);
      check("single_data", last_data, 32'h00450693);
      check("single_hold", wr_data, 32'h00450693);
      check("single_chk_err", 32'(chk_err), 32'd0);

      // Gapped stream, with a start pulse mid-load that must be ignored
      w0 = wr_cnt;
      stream = '{8'h00, 8'h45, 8'h06, 8'h93, 8'h00, 8'h10, 8'h07, 8'h13};
      run_load(2, 1'b1, 1'b0, 1'b1);
      wait_done("gapped");
      check("gapped_writes", wr_cnt - w0, 32'd2);
      check("gapped_last_adrs", 32'(last_adrs), 32'd4);
      check("gapped_hold", wr_data, 32'h00100713);

      // Full memory, then an oversized request that clamps to 32 words
      stream.delete();
      for (int w = 0; w < 32; w++) begin
         logic [31:0] word;
         word = 32'h00112233 + 32'(w) * 32'h01010101;
         for (int b = 3; b >= 0; b--) stream.push_back(word[8*b +: 8]);
      end
      for (int pass = 0; pass < 2; pass++) begin
         w0 = wr_cnt;
         d0 = done_cnt;
         run_load(pass == 0 ? 32 : 40, 1'b0, 1'b0, 1'b0);
         wait_done("full");
         check("full_writes", wr_cnt - w0, 32'd32);
         check("full_last_adrs", 32'(last_adrs), 32'd124);
         check("full_last_data", last_data, 32'h1f304152);
         check("full_one_done", done_cnt - d0, 32'd1);
      end

      // Zero words: done without writes
      w0 = wr_cnt;
      d0 = done_cnt;
      expect_latency = 1'b0;
      exp_chk        = 1'b0;
      start_load(6'd0);
      check("zero_done_now", 32'(done), 32'd1);
      wait_done("zero");
      check("zero_no_writes", wr_cnt - w0, 32'd0);
      check("zero_one_done", done_cnt - d0, 32'd1);

      // Abort after two bytes; partial word must be discarded
      w0 = wr_cnt;
      start_load(6'd1);
      send(8'h00);
      send(8'h45);
      rst = 1'b1;
      tick();
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_ready", 32'(byte_ready), 32'd0);
      rst = 1'b0;
      tick();
      check("abort_no_write", wr_cnt - w0, 32'd0);
      stream = '{8'haa, 8'hbb, 8'hcc, 8'hdd};
      run_load(1, 1'b0, 1'b0, 1'b0);
      wait_done("after_abort");
      check("after_abort_adrs", 32'(last_adrs), 32'd0);
      check("after_abort_data", last_data, 32'haabbccdd);

`ifdef INSTR_LOADER_CHECKSUM_EN
      // Trailer D0 matches 00^45^06^93; D1 does not
      stream = '{8'h00, 8'h45, 8'h06, 8'h93};
      run_load(1, 1'b0, 1'b0, 1'b0);
      wait_done("chk_good");
      check("chk_good_flag", 32'(chk_err), 32'd0);
      d0 = done_cnt;
      run_load(1, 1'b0, 1'b1, 1'b0);
      wait_done("chk_bad");
      check("chk_bad_flag", 32'(chk_err), 32'd1);
      check("chk_bad_done", done_cnt - d0, 32'd1);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
